// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue
//  Description : Instruction decode/issue stage. Holds one fetched
//                instruction, drives the register file read selects,
//                tracks in-flight destinations in a scoreboard to stall
//                on RAW/WAW hazards, and fills a registered ID/EX slot
//                through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_issue #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,        // asynchronous, active-low
    input  logic                  if_valid,
    input  logic [7:0]            if_inst,
    output logic                  if_ready,
    output logic [1:0]            re_1,
    output logic [1:0]            re_2,
    input  logic [DATA_WIDTH-1:0] rf_data_1,
    input  logic [DATA_WIDTH-1:0] rf_data_2,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [1:0]            ex_op,
    output logic [1:0]            ex_rd,
    output logic                  ex_write,
    output logic [DATA_WIDTH-1:0] ex_a,
    output logic [DATA_WIDTH-1:0] ex_b,
    input  logic                  wb_valid,
    input  logic [1:0]            wb_rd,
    input  logic                  flush
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_NOP = 2'b11;

    // Decode holding register
    logic                  r_id_valid;
    logic [7:0]            r_id_inst;

    // Scoreboard of destinations issued but not yet written back
    logic [3:0]            r_pending;

    // ID/EX slot
    logic                  r_ex_valid;
    logic [1:0]            r_ex_op;
    logic [1:0]            r_ex_rd;
    logic                  r_ex_write;
    logic [DATA_WIDTH-1:0] r_ex_a;
    logic [DATA_WIDTH-1:0] r_ex_b;

    // Decoded fields of the held instruction
    logic [1:0]            w_op;
    logic [1:0]            w_rd;
    logic [1:0]            w_rs1;
    logic [1:0]            w_rs2;
    logic                  w_uses_rs1;
    logic                  w_uses_rs2;
    logic                  w_writes;
    logic                  w_hazard;
    logic                  w_issue;
    logic                  w_if_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_opnd_a;
    logic [DATA_WIDTH-1:0] w_opnd_b;
    logic [3:0]            w_pending_nxt;

    // Field decode, hazard detection and handshake qualification
    always_comb begin
        w_op       = r_id_inst[7:6];
        w_rd       = r_id_inst[5:4];
        w_rs1      = r_id_inst[3:2];
        w_rs2      = r_id_inst[1:0];
        w_uses_rs1 = (w_op != c_OP_NOP);
        w_uses_rs2 = (w_op == c_OP_ADD) || (w_op == c_OP_SUB);
        w_writes   = (w_op != c_OP_NOP);
        // No bypass from writeback: a clear only becomes visible next cycle
        w_hazard   = r_id_valid &
                     ((w_uses_rs1 & r_pending[w_rs1]) |
                      (w_uses_rs2 & r_pending[w_rs2]) |
                      (w_writes   & r_pending[w_rd]));
        w_issue    = r_id_valid & ~w_hazard & (~r_ex_valid | ex_ready) & ~flush;
        w_if_ready = ~r_id_valid | w_issue;
        w_accept   = if_valid & w_if_ready & ~flush;
        // Unused operands are zeroed so execute sees clean values
        w_opnd_a   = w_uses_rs1 ? rf_data_1 : '0;
        w_opnd_b   = w_uses_rs2 ? rf_data_2 : '0;
    end

    // Scoreboard update: clears first, then the set from a new issue.
    // A set and a clear of the same bit cannot coincide because a
    // pending destination stalls the instruction (WAW).
    always_comb begin
        w_pending_nxt = r_pending;
        if (wb_valid) begin
            w_pending_nxt[wb_rd] = 1'b0;
        end
        if (flush && r_ex_valid && r_ex_write) begin
            w_pending_nxt[r_ex_rd] = 1'b0;
        end
        if (w_issue && w_writes) begin
            w_pending_nxt[w_rd] = 1'b1;
        end
    end

    // Decode holding register: flush squashes, otherwise load or drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= 8'h00;
        end else if (flush) begin
            r_id_valid <= 1'b0;
        end else if (w_accept) begin
            r_id_valid <= 1'b1;
            r_id_inst  <= if_inst;
        end else if (w_issue) begin
            r_id_valid <= 1'b0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 4'b0000;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // ID/EX slot: payload only changes on issue, so it holds while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= 2'b00;
            r_ex_rd    <= 2'b00;
            r_ex_write <= 1'b0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_issue) begin
            r_ex_valid <= 1'b1;
            r_ex_op    <= w_op;
            r_ex_rd    <= w_rd;
            r_ex_write <= w_writes;
            r_ex_a     <= w_opnd_a;
            r_ex_b     <= w_opnd_b;
        end else if (r_ex_valid && ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign if_ready = w_if_ready;
    assign re_1     = w_rs1;
    assign re_2     = w_rs2;
    assign ex_valid = r_ex_valid;
    assign ex_op    = r_ex_op;
    assign ex_rd    = r_ex_rd;
    assign ex_write = r_ex_write;
    assign ex_a     = r_ex_a;
    assign ex_b     = r_ex_b;

endmodule
`default_nettype wire
